// File: rtl/acam_emu_pkg.sv
// acam_emu_pkg: shared constants and the ACAM readout word layout.
// Contents: FIFO read addresses, word bit positions, t_acam_word.
package acam_emu_pkg;

    localparam logic [3:0] c_ACAM_ADDR_FIFO1 = 4'd8;
    localparam logic [3:0] c_ACAM_ADDR_FIFO2 = 4'd9;

    localparam int c_WORD_W    = 28;
    localparam int c_CHAN_LSB  = 26;
    localparam int c_START_LSB = 18;
    localparam int c_SLOPE_BIT = 17;
    localparam int c_STOP_LSB  = 0;

    typedef struct packed {
        logic [1:0]  chan;
        logic [7:0]  start_cnt;
        logic        slope;
        logic [16:0] stop;
    } t_acam_word;

endpackage

// File: rtl/acam_emu_fifo.sv
// acam_emu_fifo: one emulated ACAM hit FIFO with delayed empty flag.
// Ports: clk_i/rst_n_i clock and async active-low reset; push_i/din_i write;
// pop_i read request (ignored unless an entry is visible); dout_o head word;
// ef_o empty flag (no visible entries); ovf_o push attempted while full.
module acam_emu_fifo
    import acam_emu_pkg::*;
#(
    parameter int g_fifo_depth = 16,
    parameter int g_ef_delay   = 12
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                push_i,
    input  logic [c_WORD_W-1:0] din_i,
    input  logic                pop_i,
    output logic [c_WORD_W-1:0] dout_o,
    output logic                ef_o,
    output logic                ovf_o
);

    localparam int AW = $clog2(g_fifo_depth);
    localparam int CW = AW + 1;

    logic [c_WORD_W-1:0]   mem_q [g_fifo_depth];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d, vis_q, vis_d;
    logic [g_ef_delay-1:0] sr_q, sr_d;
    logic                  push_ok, pop_ok;

    // Full is judged on the pre-pop count, so a simultaneous pop never rescues a push.
    assign push_ok = push_i & (wr_cnt_q != CW'(g_fifo_depth));
    assign pop_ok  = pop_i & (vis_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        wr_cnt_d = wr_cnt_q + CW'(push_ok) - CW'(pop_ok);
        // An entry becomes visible when its write strobe leaves the delay line.
        vis_d    = vis_q + CW'(sr_q[g_ef_delay-1]) - CW'(pop_ok);
        sr_d     = (sr_q << 1) | g_ef_delay'(push_ok);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_cnt_q <= '0;
            vis_q    <= '0;
            sr_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_cnt_q <= wr_cnt_d;
            vis_q    <= vis_d;
            sr_q     <= sr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o = mem_q[rd_ptr_q];
    assign ef_o   = (vis_q == '0);
    assign ovf_o  = push_i & ~push_ok;

endmodule

// File: rtl/acam_emu_readout.sv
// acam_emu_readout: synthesizable emulator of the ACAM TDC-GPX readout interface.
// Ports: clk_sys_i/rst_n_i clock and async active-low reset;
// hit_valid_i/hit_ready_o/hit_channel_i/hit_ts_i/hit_start_cnt_i hit injection;
// address_i/rd_n_i ACAM read bus; data_o/data_oe_o read data and drive enable;
// ef1_o/ef2_o empty flags; err_flag_o/err_clr_i sticky overflow; underflow_o pulse.
module acam_emu_readout
    import acam_emu_pkg::*;
#(
    parameter int g_fifo_depth        = 16,
    parameter int g_channels_per_fifo = 4,
    parameter int g_num_channels      = 5,
    parameter int g_ef_delay          = 12
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        hit_valid_i,
    output logic        hit_ready_o,
    input  logic [2:0]  hit_channel_i,
    input  logic [16:0] hit_ts_i,
    input  logic [7:0]  hit_start_cnt_i,
    input  logic [3:0]  address_i,
    input  logic        rd_n_i,
    output logic [27:0] data_o,
    output logic        data_oe_o,
    output logic        ef1_o,
    output logic        ef2_o,
    output logic        err_flag_o,
    input  logic        err_clr_i,
    output logic        underflow_o
);

    logic [27:0] data_q, data_d, dout1, dout2;
    logic        data_oe_q, data_oe_d, underflow_q, underflow_d;
    logic        err_q, err_d, ready_q, rd_n_q;
    logic        in_f1, in_f2, push1, push2, fall, pop1, pop2;
    logic        ef1, ef2, ovf1, ovf2;
    logic [3:0]  ch_ext;
    t_acam_word  word;

    // Widened so that g_num_channels = 8 still compares correctly.
    assign ch_ext = {1'b0, hit_channel_i};
    assign in_f1  = ch_ext < 4'(g_channels_per_fifo);
    assign in_f2  = !in_f1 && (ch_ext < 4'(g_num_channels));
    assign push1  = hit_valid_i & ready_q & in_f1;
    assign push2  = hit_valid_i & ready_q & in_f2;

    assign word = '{
        chan:      in_f1 ? hit_channel_i[1:0] : 2'(hit_channel_i - 3'(g_channels_per_fifo)),
        start_cnt: hit_start_cnt_i,
        slope:     1'b1,
        stop:      hit_ts_i
    };

    assign fall = rd_n_q & ~rd_n_i;
    assign pop1 = fall & (address_i == c_ACAM_ADDR_FIFO1);
    assign pop2 = fall & (address_i == c_ACAM_ADDR_FIFO2);

    acam_emu_fifo #(.g_fifo_depth(g_fifo_depth), .g_ef_delay(g_ef_delay)) u_fifo1 (
        .clk_i(clk_sys_i), .rst_n_i(rst_n_i), .push_i(push1), .din_i(word),
        .pop_i(pop1), .dout_o(dout1), .ef_o(ef1), .ovf_o(ovf1)
    );

    acam_emu_fifo #(.g_fifo_depth(g_fifo_depth), .g_ef_delay(g_ef_delay)) u_fifo2 (
        .clk_i(clk_sys_i), .rst_n_i(rst_n_i), .push_i(push2), .din_i(word),
        .pop_i(pop2), .dout_o(dout2), .ef_o(ef2), .ovf_o(ovf2)
    );

    always_comb begin
        data_d      = !fall ? data_q : (pop1 & ~ef1) ? dout1 : (pop2 & ~ef2) ? dout2 : '0;
        data_oe_d   = fall | (data_oe_q & ~rd_n_i);
        underflow_d = (pop1 & ef1) | (pop2 & ef2);
        // A new overflow wins over a simultaneous clear.
        err_d       = ovf1 | ovf2 | (err_q & ~err_clr_i);
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q      <= '0;
            data_oe_q   <= 1'b0;
            underflow_q <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            rd_n_q      <= 1'b1;
        end else begin
            data_q      <= data_d;
            data_oe_q   <= data_oe_d;
            underflow_q <= underflow_d;
            err_q       <= err_d;
            ready_q     <= 1'b1;
            rd_n_q      <= rd_n_i;
        end
    end

    assign hit_ready_o = ready_q;
    assign data_o      = data_q;
    assign data_oe_o   = data_oe_q;
    assign ef1_o       = ef1;
    assign ef2_o       = ef2;
    assign err_flag_o  = err_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_acam_emu_readout.sv
// tb_acam_emu_readout: self-checking bench for acam_emu_readout (default parameters).
// Expected read words are queued per FIFO on injection and popped on each read.
module tb_acam_emu_readout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hit_valid = 1'b0;
    logic        hit_ready;
    logic [2:0]  hit_channel = '0;
    logic [16:0] hit_ts = '0;
    logic [7:0]  hit_start_cnt = '0;
    logic [3:0]  address = '0;
    logic        rd_n = 1'b1;
    logic [27:0] data;
    logic        data_oe, ef1, ef2, err_flag, underflow;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    logic [27:0] q1[$];
    logic [27:0] q2[$];

    always #5 clk = ~clk;

    acam_emu_readout dut (
        .clk_sys_i(clk), .rst_n_i(rst_n), .hit_valid_i(hit_valid), .hit_ready_o(hit_ready),
        .hit_channel_i(hit_channel), .hit_ts_i(hit_ts), .hit_start_cnt_i(hit_start_cnt),
        .address_i(address), .rd_n_i(rd_n), .data_o(data), .data_oe_o(data_oe),
        .ef1_o(ef1), .ef2_o(ef2), .err_flag_o(err_flag), .err_clr_i(err_clr),
        .underflow_o(underflow)
    );

    function automatic logic [27:0] exp_word(input int ch, input logic [16:0] ts, input logic [7:0] sc);
        logic [1:0] c;
        c = 2'(ch % 4);
        return {c, sc, 1'b1, ts};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic inject(input int ch, input logic [16:0] ts, input logic [7:0] sc);
        hit_valid = 1'b1;
        hit_channel = 3'(ch);
        hit_ts = ts;
        hit_start_cnt = sc;
        if (ch < 4) begin
            if (q1.size() < 16) q1.push_back(exp_word(ch, ts, sc));
        end else if (ch < 5) begin
            if (q2.size() < 16) q2.push_back(exp_word(ch, ts, sc));
        end
        @(posedge clk);
        #1;
        hit_valid = 1'b0;
    endtask

    // Read transaction: scoreboard pop, strobe rd_n low for two cycles, check the bus.
    task automatic do_read(input logic [3:0] addr, input string tag);
        logic [27:0] exp;
        logic exp_uf;
        logic exp_ef;
        exp = '0;
        exp_uf = 1'b0;
        if (addr == 4'd8) begin
            if (q1.size() > 0) exp = q1.pop_front(); else exp_uf = 1'b1;
        end else if (addr == 4'd9) begin
            if (q2.size() > 0) exp = q2.pop_front(); else exp_uf = 1'b1;
        end
        address = addr;
        rd_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (data !== exp) begin n_fail++; $display("FAIL %s data: got %h want %h", tag, data, exp); end
        n_checks++;
        if (data_oe !== 1'b1) begin n_fail++; $display("FAIL %s oe_on: got %b want 1", tag, data_oe); end
        n_checks++;
        if (underflow !== exp_uf) begin n_fail++; $display("FAIL %s underflow: got %b want %b", tag, underflow, exp_uf); end
        @(posedge clk);
        #1;
        n_checks++;
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL %s underflow_pulse: got %b want 0", tag, underflow); end
        n_checks++;
        if (data_oe !== 1'b1) begin n_fail++; $display("FAIL %s oe_hold: got %b want 1", tag, data_oe); end
        if (addr == 4'd8 || addr == 4'd9) begin
            exp_ef = (addr == 4'd8) ? (q1.size() == 0) : (q2.size() == 0);
            n_checks++;
            if (((addr == 4'd8) ? ef1 : ef2) !== exp_ef) begin
                n_fail++;
                $display("FAIL %s ef_after_pop: got %b want %b", tag, (addr == 4'd8) ? ef1 : ef2, exp_ef);
            end
        end
        rd_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (data_oe !== 1'b0) begin n_fail++; $display("FAIL %s oe_off: got %b want 0", tag, data_oe); end
        n_checks++;
        if (data !== exp) begin n_fail++; $display("FAIL %s data_hold: got %h want %h", tag, data, exp); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ef1, ef2, data_oe, hit_ready, err_flag, underflow} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 110000", {ef1, ef2, data_oe, hit_ready, err_flag, underflow});
        end
        n_checks++;
        if (data !== 28'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (hit_ready !== 1'b0) begin n_fail++; $display("FAIL ready_pre: got %b want 0", hit_ready); end
        @(posedge clk);
        #1;
        n_checks++;
        if (hit_ready !== 1'b1) begin n_fail++; $display("FAIL ready_post: got %b want 1", hit_ready); end
    endtask

    task automatic test_fifo1();
        inject(0, 17'h100, 8'd5);
        inject(1, 17'h200, 8'd5);
        inject(2, 17'h300, 8'd5);
        // First hit was driven in cycle 0; ef1 must fall exactly at cycle 13.
        for (int c = 3; c <= 13; c++) begin
            @(negedge clk);
            n_checks++;
            if (ef1 !== (c < 13)) begin n_fail++; $display("FAIL ef1_latency c=%0d: got %b want %b", c, ef1, c < 13); end
            @(posedge clk);
            #1;
        end
        idle(3);
        do_read(4'd8, "fifo1_rd0");
        do_read(4'd8, "fifo1_rd1");
        do_read(4'd8, "fifo1_rd2");
    endtask

    task automatic test_fifo2();
        inject(4, 17'h1FFFF, 8'd0);
        idle(14);
        n_checks++;
        if ({ef1, ef2} !== 2'b10) begin n_fail++; $display("FAIL fifo2_route: got %b want 10", {ef1, ef2}); end
        do_read(4'd9, "fifo2_rd");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                n_checks++;
                if (err_flag !== 1'b0) begin n_fail++; $display("FAIL err_before_full: got %b want 0", err_flag); end
            end
            inject(0, 17'(i * 3 + 1), 8'(i));
        end
        n_checks++;
        if (err_flag !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err_flag); end
        idle(15);
        for (int i = 0; i < 16; i++) do_read(4'd8, $sformatf("ovf_rd%0d", i));
        n_checks++;
        if (err_flag !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_flag); end
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        n_checks++;
        if (err_flag !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err_flag); end
    endtask

    task automatic test_underflow();
        inject(5, 17'h555, 8'd9);
        idle(15);
        n_checks++;
        if ({ef1, ef2} !== 2'b11) begin n_fail++; $display("FAIL bad_channel_dropped: got %b want 11", {ef1, ef2}); end
        do_read(4'd8, "uf_addr8");
        do_read(4'd3, "uf_addr3");
    endtask

    task automatic test_push_pop();
        logic [27:0] exp;
        inject(0, 17'h0AA, 8'd1);
        idle(15);
        exp = q1.pop_front();
        q1.push_back(exp_word(0, 17'h0BB, 8'd2));
        hit_valid = 1'b1;
        hit_channel = 3'd0;
        hit_ts = 17'h0BB;
        hit_start_cnt = 8'd2;
        address = 4'd8;
        rd_n = 1'b0;
        idle(1);
        hit_valid = 1'b0;
        n_checks++;
        if (data !== exp) begin n_fail++; $display("FAIL pushpop_data: got %h want %h", data, exp); end
        n_checks++;
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL pushpop_uf: got %b want 0", underflow); end
        n_checks++;
        if (ef1 !== 1'b1) begin n_fail++; $display("FAIL pushpop_ef_hidden: got %b want 1", ef1); end
        idle(1);
        rd_n = 1'b1;
        idle(14);
        n_checks++;
        if (ef1 !== 1'b0) begin n_fail++; $display("FAIL pushpop_ef_visible: got %b want 0", ef1); end
        do_read(4'd8, "pushpop_rd");
    endtask

    task automatic test_reset_mid();
        inject(0, 17'h011, 8'd3);
        inject(1, 17'h022, 8'd3);
        inject(4, 17'h033, 8'd3);
        idle(13);
        n_checks++;
        if ({ef1, ef2} !== 2'b00) begin n_fail++; $display("FAIL mid_pre_reset: got %b want 00", {ef1, ef2}); end
        hit_valid = 1'b1;
        hit_channel = 3'd0;
        #2;
        rst_n = 1'b0;
        #1;
        q1.delete();
        q2.delete();
        n_checks++;
        if ({ef1, ef2, data_oe, hit_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %b want 1100", {ef1, ef2, data_oe, hit_ready});
        end
        hit_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        do_read(4'd8, "mid_after_reset");
        idle(14);
        n_checks++;
        if ({ef1, ef2} !== 2'b11) begin n_fail++; $display("FAIL mid_flushed: got %b want 11", {ef1, ef2}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fifo1();
        test_fifo2();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
